fetch_sequencer: RTL

- Controls the 8-entry instruction memory of the 4-stage pipeline.
- Loads a program into the memory through a valid/ready byte stream.
- Then sequences the PC during execution: increment, stall hold, jump redirect and halt at end of program.
- Sits between the host/loader, the instruction memory write/read ports and the IF/ID pipeline register.

---
 rtl/fetch_sequencer_pkg.sv | 12 +
 rtl/fetch_sequencer_next_pc.sv | 22 ++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding, opcode field layout and width defaults
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
  localparam logic [1:0] JMP_OPC_DEF = 2'b11;
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;
  localparam int OFF_HI = 5;
  localparam int OFF_LO = 0;
  localparam int OFF_W = OFF_HI - OFF_LO + 1;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// fetch_next_pc: next PC (increment or PC-relative jump) and end-of-program range check
module fetch_next_pc
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [1:0] JMP_OPC = JMP_OPC_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] next_pc,
  output logic              out_of_range,
  output logic              is_jump
);
  always_comb begin
    is_jump = instr[OPC_HI:OPC_LO] == JMP_OPC;
    next_pc = pc + ADDR_W'(1) + (is_jump ? {{(ADDR_W-OFF_W){instr[OFF_HI]}}, instr[OFF_HI:OFF_LO]} : '0);
    // negative targets wrap to large unsigned values, so one compare catches both ends
    out_of_range = next_pc >= len;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program loader and PC sequencer for the instruction memory; FETCH_PERF_EN adds perf counters
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [1:0] JMP_OPC = JMP_OPC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted,
`ifdef FETCH_PERF_EN
  output logic [15:0]       perf_cycles,
  output logic [15:0]       perf_stalls,
`endif
  output logic              err
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] waddr, len, next_pc;
  logic xfer, ovf, fetch, go, oor, is_jump;

  assign xfer = load_valid & (state == LOAD);
  assign ovf = xfer & (len == ADDR_W'(DEPTH));
  assign fetch = (state == RUN) & ~stall;
  assign go = start & ((state == IDLE) | (state == HALT));

  fetch_next_pc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .JMP_OPC(JMP_OPC)) u_npc (
    .pc(pc),
    .instr(instr_in),
    .len(len),
    .next_pc(next_pc),
    .out_of_range(oor),
    .is_jump(is_jump)
  );

  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? LOAD : IDLE;
      LOAD: state_nx = ovf ? HALT : (xfer & load_last) ? RUN : LOAD;
      RUN:  state_nx = (fetch & oor) ? HALT : RUN;
      HALT: state_nx = start ? LOAD : HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_ready = state == LOAD;
    halted = state == HALT;
    mem_we = xfer & ~ovf;
    mem_waddr = waddr;
    mem_wdata = mem_we ? load_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr <= '0;
      len <= '0;
      pc <= '0;
      if_pc <= '0;
      if_instr <= '0;
      if_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      if (go) begin
        waddr <= '0;
        len <= '0;
        err <= 1'b0;
      end
      if (mem_we) begin
        waddr <= waddr + ADDR_W'(1);
        len <= len + ADDR_W'(1);
      end
      if (mem_we & load_last) pc <= '0;
      if (ovf | (fetch & oor & is_jump)) err <= 1'b1;
      if (fetch) begin
        if_instr <= instr_in;
        if_pc <= pc;
        if (!oor) pc <= next_pc;
      end
      // the halting fetch still presents its instruction; HALT then drops if_valid
      if_valid <= fetch | ((state == RUN) & stall & if_valid);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset | go) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == RUN) begin
      if (perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
      if (stall && perf_stalls != 16'hFFFF) perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif
endmodule
